// File: rtl/i2c_target_regs.sv
// I2C target responder bridging open-drain SCL/SDA pads to a byte-wide register bank.
// Pads are synchronized into clk_i; all bus events are decoded from the synced copies.
module i2c_target_regs #(
  parameter logic [6:0]  DEV_ADDR = 7'h42,
  parameter int unsigned REG_AW   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe_o,
  output logic              wr_en_o,
  output logic [REG_AW-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o,
  output logic [REG_AW-1:0] rd_addr_o,
  input  logic [7:0]        rd_data_i,
  output logic              busy_o
);

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StIgnore
  } state_e;

  localparam logic [REG_AW-1:0] PtrOne = REG_AW'(1);

  logic scl_s1_q, scl_s2_q, scl_h_q;
  logic sda_s1_q, sda_s2_q, sda_h_q;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [6:0]        shift_q, shift_d;
  logic [REG_AW-1:0] ptr_q, ptr_d;
  logic              sda_oe_q, sda_oe_d;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              rw_q, rw_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;

  // Synchronizers reset to the idle bus level so reset release cannot fake a START.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_s1_q <= 1'b1;
      scl_s2_q <= 1'b1;
      scl_h_q  <= 1'b1;
      sda_s1_q <= 1'b1;
      sda_s2_q <= 1'b1;
      sda_h_q  <= 1'b1;
    end else begin
      scl_s1_q <= scl_i;
      scl_s2_q <= scl_s1_q;
      scl_h_q  <= scl_s2_q;
      sda_s1_q <= sda_i;
      sda_s2_q <= sda_s1_q;
      sda_h_q  <= sda_s2_q;
    end
  end

  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  // SCL must be high in both samples; a same-cycle SCL/SDA change counts as data.
  assign start_det = scl_s2_q & scl_h_q & ~sda_s2_q & sda_h_q;
  assign stop_det  = scl_s2_q & scl_h_q & sda_s2_q & ~sda_h_q;
  assign byte_in   = {shift_q, sda_s2_q};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      rw_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      rw_q      <= rw_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    rw_d      = rw_q;

    if (stop_det) begin
      state_d  = StIdle;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start_det) begin
      state_d  = StAddr;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
    end else begin
      unique case (state_q)
        StAddr: begin
          if (scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (byte_in[7:1] == DEV_ADDR) begin
                rw_d    = byte_in[0];
                busy_d  = 1'b1;
                state_d = StAddrAck;
              end else begin
                busy_d  = 1'b0;
                state_d = StIgnore;
              end
            end
          end
        end

        // First SCL fall drives the ACK, the second releases it and moves on.
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              if (state_q != StAddrAck) begin
                state_d = StWdata;
              end else if (!rw_q) begin
                state_d = StPtr;
              end else begin
                state_d  = StRdata;
                shift_d  = rd_data_i[6:0];
                sda_oe_d = ~rd_data_i[7];
              end
            end
          end
        end

        StPtr: begin
          if (scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              ptr_d   = byte_in[REG_AW-1:0];
              state_d = StPtrAck;
            end
          end
        end

        StWdata: begin
          if (scl_rise) begin
            shift_d = byte_in[6:0];
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              wr_en_d   = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = byte_in;
              ptr_d     = ptr_q + PtrOne;
              state_d   = StWdataAck;
            end
          end
        end

        StRdata: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
              cnt_d    = '0;
              state_d  = StRdataAck;
            end else begin
              sda_oe_d = ~shift_q[6];
              shift_d  = {shift_q[5:0], 1'b0};
            end
          end
        end

        // cnt_q marks that the controller's ACK bit has been sampled.
        StRdataAck: begin
          if (scl_rise) begin
            ptr_d = ptr_q + PtrOne;
            if (sda_s2_q) begin
              state_d = StIgnore;
            end else begin
              cnt_d = 4'd1;
            end
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d  = StRdata;
            cnt_d    = '0;
            shift_d  = rd_data_i[6:0];
            sda_oe_d = ~rd_data_i[7];
          end
        end

        StIdle, StIgnore: begin
        end

        default: begin
          state_d  = StIdle;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  assign sda_oe_o  = sda_oe_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rd_addr_o = ptr_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C controller, table vectors, directed corner cases
// and random transactions checked against a transaction-level register-bank model.
module tb_i2c_target_regs;

  localparam logic [6:0]  Dev = 7'h42;
  localparam int unsigned Aw  = 4;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          ctrl_scl = 1'b1;
  logic          ctrl_sda = 1'b1;
  logic          sda_oe_o, wr_en_o, busy_o;
  logic [Aw-1:0] wr_addr_o, rd_addr_o;
  logic [7:0]    wr_data_o, rd_data_i;
  logic          sda_bus;

  logic [7:0]  bank [16];
  logic        bank_clr = 1'b1;
  logic [11:0] wr_log [$];
  int          oe_cnt = 0;
  int          busy_cnt = 0;

  int          n_checks = 0;
  int          n_fail = 0;
  int          model_ptr;
  logic [7:0]  model_mem [16];
  logic [11:0] exp_wr [$];

  typedef struct {
    logic [6:0]  dev;
    logic [7:0]  ptr;
    int          n;
    logic [31:0] data;
    int          exp_acks;
    int          exp_nwr;
    logic [11:0] exp_w0;
    logic [11:0] exp_w1;
    bit          exp_busy;
    int          exp_ptr;
  } wvec_t;

  always #5 clk_i = ~clk_i;

  assign sda_bus   = ctrl_sda & ~sda_oe_o;
  assign rd_data_i = bank[rd_addr_o];

  i2c_target_regs #(
    .DEV_ADDR(Dev),
    .REG_AW  (Aw)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .scl_i    (ctrl_scl),
    .sda_i    (sda_bus),
    .sda_oe_o (sda_oe_o),
    .wr_en_o  (wr_en_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i),
    .busy_o   (busy_o)
  );

  // Register bank behind the target, plus write log and activity counters.
  always @(negedge clk_i) begin
    if (bank_clr) begin
      for (int i = 0; i < 16; i++) bank[i] <= 8'h00;
    end else if (wr_en_o) begin
      bank[wr_addr_o] <= wr_data_o;
      wr_log.push_back({wr_addr_o, wr_data_o});
    end
    if (sda_oe_o) oe_cnt <= oe_cnt + 1;
    if (busy_o) busy_cnt <= busy_cnt + 1;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int idx);
    if (idx < wr_log.size()) return 32'(wr_log[idx]);
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic bus_start();
    ctrl_sda = 1'b1; tick(4);
    ctrl_scl = 1'b1; tick(8);
    ctrl_sda = 1'b0; tick(8);
    ctrl_scl = 1'b0; tick(4);
  endtask

  task automatic bus_stop();
    ctrl_sda = 1'b0; tick(4);
    ctrl_scl = 1'b1; tick(8);
    ctrl_sda = 1'b1; tick(8);
  endtask

  task automatic send_bit(input bit b);
    ctrl_sda = b;    tick(4);
    ctrl_scl = 1'b1; tick(8);
    ctrl_scl = 1'b0; tick(4);
  endtask

  task automatic recv_bit(output bit b);
    ctrl_sda = 1'b1; tick(4);
    ctrl_scl = 1'b1; tick(4);
    b = sda_bus;     tick(4);
    ctrl_scl = 1'b0; tick(4);
  endtask

  task automatic write_byte(input logic [7:0] d, output bit ack);
    bit b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(input bit nack, output logic [7:0] d);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic wr_txn(input logic [6:0] dev, input logic [7:0] ptr, input int n,
                        input logic [31:0] data, input bit stop, output int acks);
    bit a;
    acks = 0;
    bus_start();
    write_byte({dev, 1'b0}, a); acks += int'(a);
    write_byte(ptr, a);         acks += int'(a);
    for (int i = 0; i < n; i++) begin
      write_byte(data[8*i +: 8], a);
      acks += int'(a);
    end
    if (stop) bus_stop();
  endtask

  task automatic rd_txn(input int n, output logic [31:0] data, output bit aack);
    logic [7:0] b;
    data = '0;
    bus_start();
    write_byte({Dev, 1'b1}, aack);
    for (int i = 0; i < n; i++) begin
      read_byte(i == n - 1, b);
      data[8*i +: 8] = b;
    end
    bus_stop();
  endtask

  // Transaction-level model: a matching write loads the pointer, then stores bytes upward.
  task automatic model_wr(input logic [6:0] dev, input logic [7:0] ptr, input int n,
                          input logic [31:0] data, output int exp_acks);
    exp_wr.delete();
    if (dev != Dev) begin
      exp_acks = 0;
      return;
    end
    exp_acks  = 2 + n;
    model_ptr = int'(ptr) % 16;
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back({4'(model_ptr), data[8*i +: 8]});
      model_mem[model_ptr] = data[8*i +: 8];
      model_ptr = (model_ptr + 1) % 16;
    end
  endtask

  initial begin
    wvec_t       vec [5];
    int          acks, exp_acks, w0, o0, b0, n;
    logic [31:0] data, rdata;
    logic [6:0]  dev;
    logic [7:0]  ptr, rb;
    bit          aack;

    vec[0] = '{7'h42, 8'h03, 2, 32'h0000_5AA5, 4, 2, {4'h3, 8'hA5}, {4'h4, 8'h5A}, 1'b1, 5};
    vec[1] = '{7'h43, 8'h03, 2, 32'h0000_5AA5, 0, 0, 12'h000, 12'h000, 1'b0, 5};
    vec[2] = '{7'h42, 8'h0F, 2, 32'h0000_3CC3, 4, 2, {4'hF, 8'hC3}, {4'h0, 8'h3C}, 1'b1, 1};
    vec[3] = '{7'h42, 8'hF7, 1, 32'h0000_0066, 3, 1, {4'h7, 8'h66}, 12'h000, 1'b1, 8};
    vec[4] = '{7'h42, 8'h02, 2, 32'h0000_2211, 4, 2, {4'h2, 8'h11}, {4'h3, 8'h22}, 1'b1, 4};

    model_ptr = 0;
    for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;

    tick(3);
    bank_clr = 1'b0;
    check("reset sda_oe_o", 32'(sda_oe_o), 32'd0);
    check("reset wr_en_o", 32'(wr_en_o), 32'd0);
    check("reset wr_addr_o", 32'(wr_addr_o), 32'd0);
    check("reset wr_data_o", 32'(wr_data_o), 32'd0);
    check("reset busy_o", 32'(busy_o), 32'd0);
    check("reset pointer", 32'(rd_addr_o), 32'd0);
    rst_i = 1'b0;
    tick(4);

    for (int v = 0; v < 5; v++) begin
      o0 = oe_cnt;
      b0 = busy_cnt;
      w0 = wr_log.size();
      wr_txn(vec[v].dev, vec[v].ptr, vec[v].n, vec[v].data, 1'b1, acks);
      tick(2);
      check($sformatf("vec%0d acks", v), 32'(acks), 32'(vec[v].exp_acks));
      check($sformatf("vec%0d write count", v), 32'(wr_log.size() - w0), 32'(vec[v].exp_nwr));
      if (vec[v].exp_nwr > 0) check($sformatf("vec%0d write0", v), log_at(w0), 32'(vec[v].exp_w0));
      if (vec[v].exp_nwr > 1) check($sformatf("vec%0d write1", v), log_at(w0 + 1), 32'(vec[v].exp_w1));
      check($sformatf("vec%0d busy seen", v), 32'(busy_cnt > b0), 32'(vec[v].exp_busy));
      check($sformatf("vec%0d sda driven", v), 32'(oe_cnt > o0), 32'(vec[v].exp_acks != 0));
      check($sformatf("vec%0d busy after stop", v), 32'(busy_o), 32'd0);
      check($sformatf("vec%0d pointer", v), 32'(rd_addr_o), 32'(vec[v].exp_ptr));
      model_wr(vec[v].dev, vec[v].ptr, vec[v].n, vec[v].data, exp_acks);
    end

    // Pointer write, repeated START, two-byte read (ACK then NACK).
    wr_txn(Dev, 8'h02, 0, 32'h0, 1'b0, acks);
    check("rd ptr acks", 32'(acks), 32'd2);
    rd_txn(2, rdata, aack);
    tick(2);
    check("rd addr ack", 32'(aack), 32'd1);
    check("rd byte0", 32'(rdata[7:0]), 32'h11);
    check("rd byte1", 32'(rdata[15:8]), 32'h22);
    check("rd pointer after", 32'(rd_addr_o), 32'd4);
    model_wr(Dev, 8'h02, 0, 32'h0, exp_acks);
    model_ptr = 4;

    // STOP after five data bits aborts the byte.
    w0 = wr_log.size();
    wr_txn(Dev, 8'h09, 1, 32'h12, 1'b0, acks);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    bus_stop();
    tick(2);
    check("abort stop acks", 32'(acks), 32'd3);
    check("abort stop count", 32'(wr_log.size() - w0), 32'd1);
    check("abort stop write", log_at(w0), 32'h912);
    check("abort stop pointer", 32'(rd_addr_o), 32'd10);
    model_wr(Dev, 8'h09, 1, 32'h12, exp_acks);

    // Repeated START after three data bits aborts too; read lands at the loaded pointer.
    wr_txn(Dev, 8'h0B, 1, 32'h6E, 1'b1, acks);
    model_wr(Dev, 8'h0B, 1, 32'h6E, exp_acks);
    w0 = wr_log.size();
    wr_txn(Dev, 8'h0B, 0, 32'h0, 1'b0, acks);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    rd_txn(1, rdata, aack);
    tick(2);
    check("abort sr count", 32'(wr_log.size() - w0), 32'd0);
    check("abort sr read", 32'(rdata[7:0]), 32'h6E);
    check("abort sr pointer", 32'(rd_addr_o), 32'd12);
    model_ptr = 12;

    // Reset while the target drives a read bit low.
    wr_txn(Dev, 8'h05, 1, 32'h3C, 1'b1, acks);
    model_wr(Dev, 8'h05, 1, 32'h3C, exp_acks);
    wr_txn(Dev, 8'h05, 0, 32'h0, 1'b0, acks);
    bus_start();
    write_byte({Dev, 1'b1}, aack);
    check("rst addr ack", 32'(aack), 32'd1);
    check("rst sda driven", 32'(sda_oe_o), 32'd1);
    #1 rst_i = 1'b1;
    #1;
    check("rst sda released", 32'(sda_oe_o), 32'd0);
    check("rst busy", 32'(busy_o), 32'd0);
    check("rst pointer", 32'(rd_addr_o), 32'd0);
    tick(3);
    rst_i    = 1'b0;
    ctrl_scl = 1'b1;
    ctrl_sda = 1'b1;
    tick(8);
    model_ptr = 0;
    w0 = wr_log.size();
    wr_txn(Dev, 8'h01, 1, 32'h99, 1'b1, acks);
    tick(2);
    check("post rst acks", 32'(acks), 32'd3);
    check("post rst write", log_at(w0), 32'h199);
    model_wr(Dev, 8'h01, 1, 32'h99, exp_acks);

    // Random transactions against the model.
    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 2) != 2) begin
        dev  = ($urandom_range(0, 4) == 0) ? (Dev ^ 7'($urandom_range(1, 127))) : Dev;
        ptr  = 8'($urandom);
        n    = int'($urandom_range(0, 3));
        data = $urandom;
        w0   = wr_log.size();
        wr_txn(dev, ptr, n, data, 1'b1, acks);
        tick(2);
        model_wr(dev, ptr, n, data, exp_acks);
        check($sformatf("rnd%0d wr acks", t), 32'(acks), 32'(exp_acks));
        check($sformatf("rnd%0d wr count", t), 32'(wr_log.size() - w0), 32'(exp_wr.size()));
        foreach (exp_wr[k]) check($sformatf("rnd%0d wr%0d", t, k), log_at(w0 + k), 32'(exp_wr[k]));
      end else begin
        n = int'($urandom_range(1, 3));
        rd_txn(n, rdata, aack);
        tick(2);
        check($sformatf("rnd%0d rd ack", t), 32'(aack), 32'd1);
        for (int k = 0; k < n; k++) begin
          rb = model_mem[(model_ptr + k) % 16];
          check($sformatf("rnd%0d rd%0d", t, k), 32'(rdata[8*k +: 8]), 32'(rb));
        end
        model_ptr = (model_ptr + n) % 16;
      end
      check($sformatf("rnd%0d pointer", t), 32'(rd_addr_o), 32'(model_ptr));
      check($sformatf("rnd%0d busy", t), 32'(busy_o), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
